// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control: main control FSM for the multicycle MIPS datapath with
// memory stall handshake and timeout abort. Optional: MULTICYCLE_PERF_CNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_I_WB     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_LW_WB    = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FN  = 3'b111;

  localparam int              TMO_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit              TMO_EN    = (MEM_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  logic [3:0]       cur_state;
  logic [3:0]       nxt_state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_phase;
  logic             tmo_hit;
  logic             op_legal;

  assign mem_phase = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) || (cur_state == S_MEM_WR);
  // mem_ready takes priority over an expiring timeout
  assign tmo_hit   = TMO_EN && mem_phase && !mem_ready && (tmo_cnt == TMO_LIMIT);
  assign op_legal  = opcode inside {OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW,
                                    OP_BEQ, OP_BNE, OP_J};
  assign state     = cur_state;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  always_ff @(posedge clk) begin
    if (reset || !TMO_EN || !mem_phase || mem_ready || tmo_hit || (nxt_state != cur_state))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready)    nxt_state = S_DECODE;
        else if (tmo_hit) nxt_state = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                nxt_state = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI: nxt_state = S_EXEC_I;
          OP_LW, OP_SW:            nxt_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:          nxt_state = S_BRANCH;
          OP_J:                    nxt_state = S_JUMP;
          default:                 nxt_state = S_FETCH;
        endcase
      end
      S_EXEC_R:   nxt_state = S_R_WB;
      S_R_WB:     nxt_state = S_FETCH;
      S_EXEC_I:   nxt_state = S_I_WB;
      S_I_WB:     nxt_state = S_FETCH;
      S_MEM_ADDR: nxt_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)    nxt_state = S_LW_WB;
        else if (tmo_hit) nxt_state = S_FETCH;
      end
      S_LW_WB:    nxt_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready || tmo_hit) nxt_state = S_FETCH;
      end
      S_BRANCH:   nxt_state = S_FETCH;
      S_JUMP:     nxt_state = S_FETCH;
      default:    nxt_state = S_FETCH;
    endcase
  end

  // Outputs are forced to their idle values while reset is held
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_source   = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      mem_timeout = tmo_hit;
      case (cur_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'd3;
          illegal_op = !op_legal;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FN;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          if (opcode == OP_ORI)       alu_op = ALU_OR;
          else if (opcode == OP_ANDI) alu_op = ALU_AND;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_LW_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_source  = 2'd1;
          pc_write   = (opcode == OP_BNE) ? !zero : zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_source  = 2'd2;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// tb_multicycle_control: randomized self-checking bench; expected control
// timelines are generated per instruction from the instruction-level rules.
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_timeout;
  logic [3:0] state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
`ifdef MULTICYCLE_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, mwe, iod, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       rdst, m2r, rw, done, ill, tmo;
  } ctrl_t;

  typedef struct {
    ctrl_t      e;
    bit         care_aop;
    bit         rdy;
    logic [5:0] op;
    logic       z;
  } cyc_t;

  localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] J = 6'b000010;

  cyc_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;
  int   n_done   = 0;
  int   n_done_prev = 0;

  function automatic ctrl_t base(input logic [3:0] st);
    ctrl_t c;
    c     = '0;
    c.st  = st;
    c.aop = 3'b100;
    return c;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t o;
    o = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
         alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_timeout};
    return o;
  endfunction

  task automatic push(input ctrl_t c, input bit care, input bit rdy, input logic [5:0] op,
                      input logic z);
    cyc_t x;
    x.e = c; x.care_aop = care; x.rdy = rdy; x.op = op; x.z = z;
    q.push_back(x);
  endtask

  // Expected per-cycle timeline of one instruction, stalls given as unready-cycle counts
  task automatic model_instr(input logic [5:0] op, input logic z, input int fstall,
                             input int mstall);
    ctrl_t c;
    bit    is_sw;
    for (int j = 0; j < fstall; j++) begin
      c = base(4'd0); c.mreq = 1; c.asb = 2'd1; c.tmo = ((j % (TMO + 1)) == TMO);
      push(c, 1, 0, op, z);
    end
    c = base(4'd0); c.mreq = 1; c.asb = 2'd1; c.irw = 1; c.pcw = 1;
    push(c, 1, 1, op, z);
    c = base(4'd1); c.asb = 2'd3;
    c.ill = !(op inside {ADD, ADDI, ORI, ANDI, LW, SW, BEQ, BNE, J});
    push(c, 1, 1'($urandom), op, z);
    case (op)
      ADD: begin
        c = base(4'd2); c.asa = 1; c.aop = 3'b111; push(c, 1, 1'($urandom), op, z);
        c = base(4'd3); c.rdst = 1; c.rw = 1; c.done = 1; push(c, 0, 1'($urandom), op, z);
      end
      ADDI, ORI, ANDI: begin
        c = base(4'd4); c.asa = 1; c.asb = 2'd2;
        c.aop = (op == ORI) ? 3'b101 : (op == ANDI) ? 3'b110 : 3'b100;
        push(c, 1, 1'($urandom), op, z);
        c = base(4'd5); c.rw = 1; c.done = 1; push(c, 0, 1'($urandom), op, z);
      end
      LW, SW: begin
        is_sw = (op == SW);
        c = base(4'd6); c.asa = 1; c.asb = 2'd2; push(c, 1, 1'($urandom), op, z);
        for (int j = 0; j < mstall && j <= TMO; j++) begin
          c = base(is_sw ? 4'd9 : 4'd7); c.mreq = 1; c.iod = 1; c.mwe = is_sw;
          c.tmo = (j == TMO);
          push(c, 0, 0, op, z);
        end
        if (mstall <= TMO) begin
          c = base(is_sw ? 4'd9 : 4'd7); c.mreq = 1; c.iod = 1; c.mwe = is_sw; c.done = is_sw;
          push(c, 0, 1, op, z);
          if (!is_sw) begin
            c = base(4'd8); c.m2r = 1; c.rw = 1; c.done = 1; push(c, 0, 1'($urandom), op, z);
          end
        end
      end
      BEQ, BNE: begin
        c = base(4'd10); c.asa = 1; c.aop = 3'b001; c.pcs = 2'd1;
        c.pcw = (op == BEQ) ? z : !z; c.done = 1;
        push(c, 1, 1'($urandom), op, z);
      end
      J: begin
        c = base(4'd11); c.pcs = 2'd2; c.pcw = 1; c.done = 1; push(c, 0, 1'($urandom), op, z);
      end
      default: ;
    endcase
  endtask

  // Drives the next expected cycle's inputs and samples the outputs mid-cycle
  task automatic play_cycle(output cyc_t x, output ctrl_t o);
    @(posedge clk); #1;
    x         = q.pop_front();
    reset     = 1'b0;
    mem_ready = x.rdy;
    opcode    = (x.e.st == 4'd0) ? 6'($urandom) : x.op;
    zero      = x.z;
    @(negedge clk);
    o = sample();
    if (!x.care_aop) o.aop = x.e.aop;
    n_cyc++;
    n_done_prev = n_done;
    if (x.e.done) n_done++;
  endtask

  task automatic test_reset();
    ctrl_t o;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'd0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = sample();
    n_assert++;
    if (o !== base(4'd0)) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", o, base(4'd0));
    end
    n_cyc = 0; n_done = 0;
  endtask

  task automatic test_rtype_imm();
    cyc_t x; ctrl_t o;
    model_instr(ADD, 0, 0, 0); model_instr(ORI, 0, 0, 0);
    model_instr(ANDI, 1, 1, 0); model_instr(ADDI, 0, 2, 0);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL alu_instr op=%b: got %h expected %h", x.op, o, x.e);
      end
    end
  endtask

  task automatic test_load_store();
    cyc_t x; ctrl_t o;
    model_instr(LW, 0, 0, 3); model_instr(SW, 1, 0, 0);
    model_instr(SW, 0, 2, 2); model_instr(LW, 1, 0, TMO);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL load_store op=%b: got %h expected %h", x.op, o, x.e);
      end
    end
  endtask

  task automatic test_branch_jump();
    cyc_t x; ctrl_t o;
    model_instr(BEQ, 1, 0, 0); model_instr(BNE, 1, 0, 0);
    model_instr(BEQ, 0, 0, 0); model_instr(BNE, 0, 0, 0);
    model_instr(J, 0, 0, 0);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL branch_jump op=%b z=%b: got %h expected %h", x.op, x.z, o, x.e);
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t x; ctrl_t o;
    model_instr(6'b111111, 0, 0, 0); model_instr(6'b010000, 0, 0, 0);
    model_instr(ADD, 0, 0, 0);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL illegal_op op=%b: got %h expected %h", x.op, o, x.e);
      end
    end
  endtask

  task automatic test_timeout();
    cyc_t x; ctrl_t o;
    model_instr(J, 0, 2 * (TMO + 1) + 2, 0);
    model_instr(LW, 0, 0, TMO + 1);
    model_instr(SW, 0, 0, TMO + 3);
    model_instr(ADDI, 0, TMO, 0);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL timeout op=%b: got %h expected %h", x.op, o, x.e);
      end
    end
  endtask

  task automatic test_reset_mid_instr();
    cyc_t x; ctrl_t o;
    model_instr(SW, 0, 0, 3);
    for (int i = 0; i < 4; i++) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL reset_mid_pre: got %h expected %h", o, x.e);
      end
    end
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1; opcode = SW;
    @(negedge clk);
    n_assert++;
    if ({instr_done, mem_req, mem_we, reg_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_gate: got done/req/we/rw=%b expected 0000",
                         {instr_done, mem_req, mem_we, reg_write});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++;
    if ({state, mem_req} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_mid_state: got state=%0d mem_req=%b expected 0/0", state, mem_req);
    end
    n_cyc = 0; n_done = 0;
    model_instr(ADD, 0, 1, 0);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if (o !== x.e) begin
        n_fail++; $display("FAIL reset_mid_post: got %h expected %h", o, x.e);
      end
    end
  endtask

  task automatic test_random();
    cyc_t x; ctrl_t o;
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{ADD, ADDI, ORI, ANDI, LW, SW, BEQ, BNE, J};
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      model_instr(op, 1'($urandom), $urandom_range(0, 6), $urandom_range(0, 6));
      while (q.size() > 0) begin
        play_cycle(x, o);
        n_assert++;
        if (o !== x.e) begin
          n_fail++; $display("FAIL random op=%b: got %h expected %h", x.op, o, x.e);
        end
      end
    end
  endtask

`ifdef MULTICYCLE_PERF_CNT_EN
  task automatic test_perf_counters();
    cyc_t x; ctrl_t o;
    test_reset();
    model_instr(ADD, 0, 1, 0); model_instr(LW, 0, 0, 2); model_instr(6'b111111, 0, 0, 0);
    model_instr(SW, 0, 0, TMO + 1); model_instr(J, 0, 0, 0);
    while (q.size() > 0) begin
      play_cycle(x, o);
      n_assert++;
      if ({cycle_cnt, instr_cnt} !== {32'(n_cyc - 1), 32'(n_done_prev)}) begin
        n_fail++; $display("FAIL perf_cnt: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                           cycle_cnt, instr_cnt, n_cyc - 1, n_done_prev);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype_imm();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_instr();
    test_random();
`ifdef MULTICYCLE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
